div_clk_monitor: RTL

//  Consumer stage for the ripple-counter divided clock. Samples div_clk in the clk_in domain through a

---
 rtl/div_clk_monitor_if.sv | 32 +++
 rtl/div_clk_monitor.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/div_clk_monitor_if.sv
// Signal bundle between a divided-clock source/consumer and div_clk_monitor.
// The DUT uses the slave modport; whoever drives div_clk/en/err_clr uses master.
interface div_clk_monitor_if #(
    parameter int CNT_W = 16
);
    // period_vld is a valid-only strobe: there is no ready, so the consumer
    // must capture period in the single cycle period_vld is high.
    logic             div_clk;
    logic             en;
    logic             err_clr;
    logic             rise_tick;
    logic             fall_tick;
    logic [CNT_W-1:0] period;
    logic             period_vld;
    logic             locked;
    logic             err;
    logic [CNT_W-1:0] high_time;
    logic             duty_err;
    logic [1:0]       dbg_state;

    modport master (
        output div_clk, en, err_clr,
        input  rise_tick, fall_tick, period, period_vld, locked, err,
               high_time, duty_err, dbg_state
    );

    modport slave (
        input  div_clk, en, err_clr,
        output rise_tick, fall_tick, period, period_vld, locked, err,
               high_time, duty_err, dbg_state
    );
endinterface

// File: rtl/div_clk_monitor.sv
// Synchronizes a divided clock into clk_in, emits rise/fall ticks, measures its period and tracks lock.
// Optional duty-cycle measurement is built when DIV_MON_DUTY_EN is defined.
module div_clk_monitor #(
    parameter int N           = 16,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16,
    parameter int TOL         = 0,
    parameter int LOCK_COUNT  = 4
) (
    input  logic               clk_in,
    input  logic               rstn,
    div_clk_monitor_if.slave   mon
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEEK  = 2'd1,
        TRACK = 2'd2,
        LOCK  = 2'd3
    } state_e;

    localparam int               GW      = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TMO     = CNT_W'(2 * N - 1);
    localparam logic [CNT_W:0]   N_W     = (CNT_W + 1)'(N);
    localparam logic [CNT_W:0]   TOL_W   = (CNT_W + 1)'(TOL);
    localparam logic [GW-1:0]    LC_W    = GW'(LOCK_COUNT);

    function automatic logic [CNT_W:0] abs_diff(input logic [CNT_W:0] a, input logic [CNT_W:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   edge_q, edge_d;
    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [GW-1:0]          good_q, good_d;
    logic                   rise_tick_q, rise_tick_d;
    logic                   fall_tick_q, fall_tick_d;
    logic [CNT_W-1:0]       period_q, period_d;
    logic                   period_vld_q, period_vld_d;
    logic                   locked_q, locked_d;
    logic                   err_q, err_d;

    logic                   rise_evt, fall_evt, match, timeout, err_set;
    logic [CNT_W:0]         period_new;
    logic [GW-1:0]          good_inc;

    // Edge detection looks at the synchronizer output and its one-cycle delay.
    assign rise_evt   = sync_q[SYNC_STAGES-1] & ~edge_q;
    assign fall_evt   = ~sync_q[SYNC_STAGES-1] & edge_q;
    assign period_new = {1'b0, cnt_q} + (CNT_W + 1)'(1);
    assign match      = abs_diff(period_new, N_W) <= TOL_W;
    assign timeout    = cnt_q >= TMO;
    assign good_inc   = good_q + GW'(1);

    always_comb begin
        sync_d       = {sync_q[SYNC_STAGES-2:0], mon.div_clk};
        edge_d       = sync_q[SYNC_STAGES-1];
        state_d      = state_q;
        good_d       = good_q;
        period_d     = period_q;
        period_vld_d = 1'b0;
        err_set      = 1'b0;
        if (rise_evt)              cnt_d = '0;
        else if (cnt_q == CNT_MAX) cnt_d = cnt_q;
        else                       cnt_d = cnt_q + CNT_W'(1);

        case (state_q)
            IDLE: begin
                cnt_d   = '0;
                good_d  = '0;
                state_d = SEEK;
            end
            SEEK: begin
                if (rise_evt) begin
                    state_d = TRACK;
                    good_d  = '0;
                end
            end
            TRACK: begin
                if (rise_evt) begin
                    period_vld_d = 1'b1;
                    period_d     = period_new[CNT_W-1:0];
                    if (match) begin
                        good_d = good_inc;
                        if (good_inc == LC_W) state_d = LOCK;
                    end else begin
                        good_d = '0;
                    end
                end else if (timeout) begin
                    state_d = SEEK;
                end
            end
            LOCK: begin
                if (rise_evt) begin
                    period_vld_d = 1'b1;
                    period_d     = period_new[CNT_W-1:0];
                    if (!match) begin
                        err_set = 1'b1;
                        state_d = TRACK;
                        good_d  = '0;
                    end
                end else if (timeout) begin
                    err_set = 1'b1;
                    state_d = SEEK;
                end
            end
            default: state_d = IDLE;
        endcase

        // Dropping en overrides everything; period and err simply hold.
        if (!mon.en) begin
            state_d      = IDLE;
            cnt_d        = '0;
            good_d       = '0;
            period_d     = period_q;
            period_vld_d = 1'b0;
            err_set      = 1'b0;
        end

        err_d       = err_set ? 1'b1 : (mon.err_clr ? 1'b0 : err_q);
        locked_d    = (state_d == LOCK);
        rise_tick_d = rise_evt & mon.en;
        fall_tick_d = fall_evt & mon.en;
    end

    always_ff @(posedge clk_in or negedge rstn) begin
        if (!rstn) begin
            sync_q       <= '0;
            edge_q       <= 1'b0;
            state_q      <= IDLE;
            cnt_q        <= '0;
            good_q       <= '0;
            rise_tick_q  <= 1'b0;
            fall_tick_q  <= 1'b0;
            period_q     <= '0;
            period_vld_q <= 1'b0;
            locked_q     <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            edge_q       <= edge_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            good_q       <= good_d;
            rise_tick_q  <= rise_tick_d;
            fall_tick_q  <= fall_tick_d;
            period_q     <= period_d;
            period_vld_q <= period_vld_d;
            locked_q     <= locked_d;
            err_q        <= err_d;
        end
    end

`ifdef DIV_MON_DUTY_EN
    localparam logic [CNT_W:0] HALF_W = (CNT_W + 1)'(N / 2);

    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] high_time_q, high_time_d;
    logic             duty_err_q, duty_err_d;
    logic [CNT_W:0]   high_new;
    logic             duty_set;

    assign high_new = {1'b0, hcnt_q} + (CNT_W + 1)'(1);

    // High phase is only meaningful once a measured rise has anchored hcnt.
    always_comb begin
        high_time_d = high_time_q;
        duty_set    = 1'b0;
        if (rise_evt)               hcnt_d = '0;
        else if (hcnt_q == CNT_MAX) hcnt_d = hcnt_q;
        else                        hcnt_d = hcnt_q + CNT_W'(1);
        if (mon.en && fall_evt && (state_q == TRACK || state_q == LOCK)) begin
            high_time_d = high_new[CNT_W-1:0];
            duty_set    = (state_q == LOCK) && (abs_diff(high_new, HALF_W) > TOL_W);
        end
        duty_err_d = duty_set ? 1'b1 : (mon.err_clr ? 1'b0 : duty_err_q);
    end

    always_ff @(posedge clk_in or negedge rstn) begin
        if (!rstn) begin
            hcnt_q      <= '0;
            high_time_q <= '0;
            duty_err_q  <= 1'b0;
        end else begin
            hcnt_q      <= hcnt_d;
            high_time_q <= high_time_d;
            duty_err_q  <= duty_err_d;
        end
    end

    assign mon.high_time = high_time_q;
    assign mon.duty_err  = duty_err_q;
`else
    assign mon.high_time = '0;
    assign mon.duty_err  = 1'b0;
`endif

    assign mon.rise_tick  = rise_tick_q;
    assign mon.fall_tick  = fall_tick_q;
    assign mon.period     = period_q;
    assign mon.period_vld = period_vld_q;
    assign mon.locked     = locked_q;
    assign mon.err        = err_q;
    assign mon.dbg_state  = state_q;
endmodule
